// File: rtl/sdram_pkg.sv
// Shared types and sizing helpers for the SDRAM request-port arbiter.
package sdram_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int TIMEOUT_CNT_W = $clog2(DEFAULT_TIMEOUT_CYCLES);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_select #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 valid,
  output logic [IDX_W-1:0]     grant
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = |req;
    grant = '0;
    cand  = '0;
    // Walk backwards so the requester nearest after last_grant is written last.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
      if (req[cand]) grant = cand;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-port round-robin front end for the SDRAM controller request port, with
// per-transaction timeout and illegal (read+write) request rejection.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_LEN       = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*WORD_LEN-1:0]    p_wr,
  input  logic [NUM_PORTS-1:0]             p_rd,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_write_data,
  output logic [NUM_PORTS-1:0]             p_rdy,
  output logic [NUM_PORTS-1:0]             p_rvalid,
  output logic [NUM_PORTS-1:0]             p_wvalid,
  output logic [NUM_PORTS-1:0]             p_error,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  p_read_data,
  output logic [WORD_LEN-1:0]              m_wr,
  output logic                             m_rd,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_write_data,
  input  logic                             m_rdy,
  input  logic                             m_rvalid,
  input  logic                             m_wvalid,
  input  logic                             m_error,
  input  logic [DATA_WIDTH-1:0]            m_read_data
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  logic [WORD_LEN-1:0]   wr_a    [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];
  logic [NUM_PORTS-1:0]  req;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      wr_a[i]    = p_wr[i*WORD_LEN +: WORD_LEN];
      addr_a[i]  = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = p_write_data[i*DATA_WIDTH +: DATA_WIDTH];
      req[i]     = (|wr_a[i]) | p_rd[i];
    end
  end

  arb_state_t            state_q, state_d;
  op_t                   op_q, op_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-1:0]   m_wr_d;
  logic                  m_rd_d;
  logic [NUM_PORTS-1:0]  p_rdy_d, p_rvalid_d, p_wvalid_d, p_error_d;
  logic                  rd_load;
  logic                  sel_valid;
  logic [IDX_W-1:0]      sel;

  rr_select #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr_select (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (sel_valid),
    .grant      (sel)
  );

  assign m_addr       = addr_q;
  assign m_write_data = wdata_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m_wr_d       = m_wr;
    m_rd_d       = m_rd;
    p_rdy_d      = '0;
    p_rvalid_d   = '0;
    p_wvalid_d   = '0;
    p_error_d    = '0;
    rd_load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          p_rdy_d[sel] = 1'b1;
          if ((|wr_a[sel]) && p_rd[sel]) begin
            p_error_d[sel] = 1'b1;
            last_grant_d   = sel;
          end else begin
            grant_d = sel;
            op_d    = p_rd[sel] ? OP_RD : OP_WR;
            addr_d  = addr_a[sel];
            wdata_d = wdata_a[sel];
            m_wr_d  = wr_a[sel];
            m_rd_d  = p_rd[sel];
            cnt_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_LAST) begin
          p_error_d[grant_q] = 1'b1;
          m_wr_d       = '0;
          m_rd_d       = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (m_rdy) begin
            m_wr_d  = '0;
            m_rd_d  = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Completions of the wrong type fall through to the timeout path.
        if (m_error) begin
          p_error_d[grant_q] = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (op_q == OP_WR && m_wvalid) begin
          p_wvalid_d[grant_q] = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (op_q == OP_RD && m_rvalid) begin
          p_rvalid_d[grant_q] = 1'b1;
          rd_load      = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          p_error_d[grant_q] = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_RD;
      last_grant_q <= LAST_PORT;
      grant_q      <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m_wr         <= '0;
      m_rd         <= 1'b0;
      p_rdy        <= '0;
      p_rvalid     <= '0;
      p_wvalid     <= '0;
      p_error      <= '0;
      p_read_data  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m_wr         <= m_wr_d;
      m_rd         <= m_rd_d;
      p_rdy        <= p_rdy_d;
      p_rvalid     <= p_rvalid_d;
      p_wvalid     <= p_wvalid_d;
      p_error      <= p_error_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rd_load && grant_q == IDX_W'(i)) p_read_data[i*DATA_WIDTH +: DATA_WIDTH] <= m_read_data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: 4 ports, 32-bit, timeout of 16 cycles.
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WL = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*WL-1:0]  p_wr;
  logic [NP-1:0]     p_rd;
  logic [NP*AW-1:0]  p_addr;
  logic [NP*DW-1:0]  p_write_data;
  logic [NP-1:0]     p_rdy, p_rvalid, p_wvalid, p_error;
  logic [NP*DW-1:0]  p_read_data;
  logic [WL-1:0]     m_wr;
  logic              m_rd;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_write_data;
  logic              m_rdy, m_rvalid, m_wvalid, m_error;
  logic [DW-1:0]     m_read_data;

  logic [WL-1:0]     a_wr    [NP];
  logic [AW-1:0]     a_addr  [NP];
  logic [DW-1:0]     a_wdata [NP];
  logic [DW-1:0]     r_data  [NP];

  int n_tests = 0;
  int n_fail  = 0;
  int order [6] = '{0, 1, 3, 0, 1, 3};

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign p_wr[g*WL +: WL]         = a_wr[g];
    assign p_addr[g*AW +: AW]       = a_addr[g];
    assign p_write_data[g*DW +: DW] = a_wdata[g];
    assign r_data[g]                = p_read_data[g*DW +: DW];
  end

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .p_wr(p_wr), .p_rd(p_rd), .p_addr(p_addr), .p_write_data(p_write_data),
    .p_rdy(p_rdy), .p_rvalid(p_rvalid), .p_wvalid(p_wvalid), .p_error(p_error),
    .p_read_data(p_read_data),
    .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_write_data(m_write_data),
    .m_rdy(m_rdy), .m_rvalid(m_rvalid), .m_wvalid(m_wvalid), .m_error(m_error),
    .m_read_data(m_read_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept after rdy_dly idle cycles, then complete cmp_dly cycles later.
  task automatic serve(input int rdy_dly, input int cmp_dly,
                       input logic rv, input logic wv, input logic er,
                       input logic [DW-1:0] rdata);
    repeat (rdy_dly) tick();
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    repeat (cmp_dly) tick();
    m_rvalid = rv; m_wvalid = wv; m_error = er; m_read_data = rdata;
    tick();
    m_rvalid = 1'b0; m_wvalid = 1'b0; m_error = 1'b0; m_read_data = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    p_rd = '0;
    m_rdy = 1'b0; m_rvalid = 1'b0; m_wvalid = 1'b0; m_error = 1'b0; m_read_data = '0;
    for (int i = 0; i < NP; i++) begin
      a_wr[i] = '0; a_addr[i] = '0; a_wdata[i] = '0;
    end
    repeat (2) tick();
    chk("rst_pulses", {p_rdy, p_rvalid, p_wvalid, p_error}, 16'h0);
    chk("rst_m_req", {m_wr, m_rd}, 5'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_rdata", p_read_data, 128'h0);
    rst = 1'b0;
    tick();

    // Single read from port 0
    a_addr[0] = 32'h100; p_rd[0] = 1'b1;
    tick();
    chk("rd_rdy", p_rdy, 4'b0001);
    chk("rd_m_rd", m_rd, 1'b1);
    chk("rd_m_wr", m_wr, 4'h0);
    chk("rd_m_addr", m_addr, 32'h100);
    p_rd[0] = 1'b0;
    tick();
    chk("rd_rdy_pulse", p_rdy, 4'b0000);
    chk("rd_hold", {m_rd, m_addr}, {1'b1, 32'h100});
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    chk("rd_release", m_rd, 1'b0);
    repeat (4) tick();
    chk("rd_no_early", p_rvalid, 4'b0000);
    m_rvalid = 1'b1; m_read_data = 32'hDEADBEEF;
    tick();
    m_rvalid = 1'b0; m_read_data = '0;
    chk("rd_rvalid", p_rvalid, 4'b0001);
    chk("rd_data", r_data[0], 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_pulse", p_rvalid, 4'b0000);
    chk("rd_data_hold", r_data[0], 32'hDEADBEEF);

    // Round robin over ports 0,1,3 after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) a_addr[i] = 32'h1000 + 32'(i * 16);
    p_rd = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_grant%0d", k), p_rdy, 128'(1) << order[k]);
      chk($sformatf("rr_addr%0d", k), m_addr, 32'h1000 + 32'(order[k] * 16));
      p_rd[order[k]] = 1'b0;
      serve(0, 1, 1'b1, 1'b0, 1'b0, 32'h5000 + 32'(k));
      chk($sformatf("rr_rvalid%0d", k), p_rvalid, 128'(1) << order[k]);
      chk($sformatf("rr_data%0d", k), r_data[order[k]], 32'h5000 + 32'(k));
      p_rd[order[k]] = 1'b1;
    end
    p_rd = '0;

    // Byte-masked write from port 2
    a_wr[2] = 4'b0101; a_wdata[2] = 32'hA5A5A5A5; a_addr[2] = 32'h40;
    tick();
    chk("wr_rdy", p_rdy, 4'b0100);
    chk("wr_m_wr", m_wr, 4'b0101);
    chk("wr_m_rd", m_rd, 1'b0);
    chk("wr_m_data", m_write_data, 32'hA5A5A5A5);
    chk("wr_m_addr", m_addr, 32'h40);
    a_wr[2] = '0;
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    chk("wr_release", m_wr, 4'h0);
    m_rvalid = 1'b1; m_read_data = 32'h1234;
    tick();
    m_rvalid = 1'b0; m_read_data = '0;
    chk("wr_ignore_rvalid", {p_rvalid, p_wvalid}, 8'h00);
    m_wvalid = 1'b1;
    tick();
    m_wvalid = 1'b0;
    chk("wr_wvalid", p_wvalid, 4'b0100);
    chk("wr_others", {p_rvalid, p_error}, 8'h00);
    chk("wr_no_rdata", r_data[2], 32'h0);

    // Downstream error on a port 1 read, asserted alongside rvalid
    a_addr[1] = 32'h80; p_rd[1] = 1'b1;
    tick();
    chk("err_rdy", p_rdy, 4'b0010);
    p_rd[1] = 1'b0;
    serve(1, 0, 1'b1, 1'b0, 1'b1, 32'hBAD0BAD0);
    chk("err_error", p_error, 4'b0010);
    chk("err_no_rvalid", p_rvalid, 4'b0000);
    chk("err_data_kept", r_data[1], 32'h5004);

    // Illegal request: port 3 asks for read and write together
    a_wr[3] = 4'hF; p_rd[3] = 1'b1;
    tick();
    chk("ill_rdy", p_rdy, 4'b1000);
    chk("ill_error", p_error, 4'b1000);
    chk("ill_no_down", {m_wr, m_rd}, 5'h0);
    a_wr[3] = '0; p_rd[3] = 1'b0;
    tick();
    chk("ill_pulse", {p_rdy, p_error}, 8'h00);

    // Timeout on port 0 with port 2 pending
    a_addr[0] = 32'h200; p_rd[0] = 1'b1;
    a_addr[2] = 32'h240; p_rd[2] = 1'b1;
    tick();
    chk("to_rdy", p_rdy, 4'b0001);
    chk("to_addr", m_addr, 32'h200);
    p_rd[0] = 1'b0;
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    repeat (TO - 2) tick();
    chk("to_not_yet", {p_error, p_rdy}, 8'h00);
    tick();
    chk("to_error", p_error, 4'b0001);
    chk("to_no_rvalid", p_rvalid, 4'b0000);
    m_rvalid = 1'b1; m_read_data = 32'hCAFE;
    tick();
    m_rvalid = 1'b0; m_read_data = '0;
    chk("to_next_grant", p_rdy, 4'b0100);
    chk("to_next_addr", m_addr, 32'h240);
    chk("to_stray", p_rvalid, 4'b0000);
    chk("to_stray_data", r_data[0], 32'h5003);
    p_rd[2] = 1'b0;

    // Reset while port 2's read is outstanding
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_pulses", {p_rdy, p_rvalid, p_wvalid, p_error}, 16'h0);
    chk("arst_m", {m_wr, m_rd, m_addr, m_write_data}, 69'h0);
    chk("arst_rdata", p_read_data, 128'h0);
    tick();
    rst = 1'b0;
    p_rd[0] = 1'b1; p_rd[3] = 1'b1;
    m_rvalid = 1'b1; m_wvalid = 1'b1;
    tick();
    m_rvalid = 1'b0; m_wvalid = 1'b0;
    chk("arst_prio", p_rdy, 4'b0001);
    chk("arst_no_stale", {p_rvalid, p_wvalid, p_error}, 12'h0);
    p_rd[0] = 1'b0;
    serve(0, 0, 1'b1, 1'b0, 1'b0, 32'h77);
    chk("arst_done", p_rvalid, 4'b0001);

    // Port 3 alone, holding its request: granted on every IDLE cycle
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("b2b_rdy%0d", k), p_rdy, 4'b1000);
      serve(0, 0, 1'b1, 1'b0, 1'b0, 32'h900 + 32'(k));
      chk($sformatf("b2b_data%0d", k), r_data[3], 32'h900 + 32'(k));
    end
    p_rd = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
